// File: rtl/flash_bus_cycle_sequencer.sv
// ----------------------------------------------------------------------------
// flash_bus_cycle_sequencer
//
// Bus-cycle timing stage that sits behind the FLASH_KICKSTART address decoder.
// Once the decoder selects flash for a 68000 cycle, this block produces:
//   - the flash /OE strobes for reads,
//   - the /WE strobes for writes, with parameterised setup and pulse width,
//   - a locally generated /DTACK,
//   - /BERR when a selected write never presents a data strobe.
// Everything runs in the MB_CLK (7 MHz) domain. The 68000 inputs are sampled
// directly, with no synchronisers.
//
// Parameters
//   READ_WAIT   extra MB_CLK cycles between read select and /DTACK (0..15)
//   WR_SETUP    setup is WR_SETUP+1 cycles, from the edge that samples DS low,
//               before /WE falls (0..15)
//   WE_WIDTH    cycles /WE is held low (1..15)
//   DS_TIMEOUT  cycles allowed waiting for a write data strobe (1..15)
//
// Ports
//   MB_CLK     in   motherboard clock, the only clock
//   RESET      in   asynchronous active-low reset
//   CPU_AS     in   68000 /AS, active low
//   RW         in   68000 R/W (1 = read)
//   UDS, LDS   in   upper/lower data strobes, active low
//   FLASH_SEL  in   decoded flash select, valid while CPU_AS is low
//   FLASH_RD   out  flash /OE {upper,lower}, active low, combinational
//   FLASH_WR   out  flash /WE {upper,lower}, active low, registered
//   MB_DTACK   out  0 while acknowledging, otherwise released (Z)
//   MB_BERR    out  0 while signalling a bus error, otherwise released (Z)
// ----------------------------------------------------------------------------
module flash_bus_cycle_sequencer #(
    parameter int unsigned READ_WAIT  = 1,
    parameter int unsigned WR_SETUP   = 1,
    parameter int unsigned WE_WIDTH   = 2,
    parameter int unsigned DS_TIMEOUT = 12
) (
    input  logic       MB_CLK,
    input  logic       RESET,
    input  logic       CPU_AS,
    input  logic       RW,
    input  logic       UDS,
    input  logic       LDS,
    input  logic       FLASH_SEL,
    output logic [1:0] FLASH_RD,
    output logic [1:0] FLASH_WR,
    output logic       MB_DTACK,
    output logic       MB_BERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT_DS,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_ACK,
        S_ERR
    } state_t;

    localparam logic [3:0] READ_WAIT_C   = 4'(READ_WAIT);
    localparam logic [3:0] WR_SETUP_C    = 4'(WR_SETUP);
    localparam logic [3:0] WE_WIDTH_M1_C = 4'(WE_WIDTH - 1);
    localparam logic [3:0] DS_TIMEOUT_C  = 4'(DS_TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       rw_l;
    logic       rw_l_nxt;
    logic [1:0] ds_l;
    logic [1:0] ds_l_nxt;
    logic       as_prev;   // CPU_AS as sampled on the previous edge
    logic       ds_active;

    assign ds_active = ~(UDS & LDS);

    // ------------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        rw_l_nxt  = rw_l;
        ds_l_nxt  = ds_l;

        if (state != S_IDLE && CPU_AS) begin
            // /AS released: normal end of ACK/ERR, or an abort anywhere else.
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    // as_prev forces /AS to be seen high between cycles, so
                    // one /AS assertion yields exactly one acknowledge, and a
                    // cycle not selected at its first sample stays with the
                    // motherboard.
                    if (!CPU_AS && FLASH_SEL && as_prev) begin
                        rw_l_nxt = RW;
                        if (RW) begin
                            state_nxt = S_RD_WAIT;
                            cnt_nxt   = READ_WAIT_C;
                        end else begin
                            state_nxt = S_WR_WAIT_DS;
                            cnt_nxt   = 4'd0;
                        end
                    end
                end

                S_RD_WAIT: begin
                    if (cnt == 4'd0) state_nxt = S_ACK;
                    else             cnt_nxt   = cnt - 4'd1;
                end

                S_WR_WAIT_DS: begin
                    // Counts up here; a strobe wins over the timeout on the
                    // same edge.
                    if (ds_active) begin
                        ds_l_nxt  = {UDS, LDS};
                        state_nxt = S_WR_SETUP;
                        cnt_nxt   = WR_SETUP_C;
                    end else if (cnt == DS_TIMEOUT_C) begin
                        state_nxt = S_ERR;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end

                S_WR_SETUP: begin
                    if (cnt == 4'd0) begin
                        state_nxt = S_WR_PULSE;
                        cnt_nxt   = WE_WIDTH_M1_C;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end

                S_WR_PULSE: begin
                    if (cnt == 4'd0) state_nxt = S_WR_HOLD;
                    else             cnt_nxt   = cnt - 4'd1;
                end

                S_WR_HOLD: state_nxt = S_ACK;

                S_ACK, S_ERR: state_nxt = state;

                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers. /WE is registered straight from the next state, so it
    // is low exactly while in WR_PULSE and uses the latched strobes, never the
    // live ones.
    // ------------------------------------------------------------------------
    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            rw_l     <= 1'b0;
            ds_l     <= 2'b11;
            as_prev  <= 1'b0;
            FLASH_WR <= 2'b11;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register updates from values sampled before this edge.
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rw_l     <= rw_l_nxt;
            ds_l     <= ds_l_nxt;
            as_prev  <= CPU_AS;
            FLASH_WR <= (state_nxt == S_WR_PULSE) ? ds_l_nxt : 2'b11;
        end
    end

    // /OE follows the live strobes during a read and drops away the moment
    // /AS rises, without waiting for a clock edge.
    assign FLASH_RD = ((state == S_RD_WAIT || state == S_ACK) && rw_l && !CPU_AS)
                    ? {UDS, LDS} : 2'b11;

    // Open-drain style bus outputs; ACK and ERR are distinct states, so the two
    // are never driven together.
    assign MB_DTACK = (state == S_ACK) ? 1'b0 : 1'bz;
    assign MB_BERR  = (state == S_ERR) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_flash_bus_cycle_sequencer.sv
// ----------------------------------------------------------------------------
// tb_flash_bus_cycle_sequencer
//
// Directed bench for flash_bus_cycle_sequencer. A timestamp model records the
// edge at which each flash cycle started and the edge at which its write
// strobe was first seen, and derives every expected output from those times
// with plain arithmetic. A compare process checks all outputs on every falling
// edge. Literal checks in the directed sequences pin the model itself.
// /DTACK and /BERR carry pull-ups, so "released" reads as 1.
// ----------------------------------------------------------------------------
module tb_flash_bus_cycle_sequencer;

    localparam int READ_WAIT  = 1;
    localparam int WR_SETUP   = 1;
    localparam int WE_WIDTH   = 2;
    localparam int DS_TIMEOUT = 12;

    logic       clk;
    logic       rst_n;
    logic       cpu_as;
    logic       rw;
    logic       uds;
    logic       lds;
    logic       flash_sel;
    wire  [1:0] flash_rd;
    wire  [1:0] flash_wr;
    wire        mb_dtack;
    wire        mb_berr;

    pullup (mb_dtack);
    pullup (mb_berr);

    flash_bus_cycle_sequencer #(
        .READ_WAIT (READ_WAIT),
        .WR_SETUP  (WR_SETUP),
        .WE_WIDTH  (WE_WIDTH),
        .DS_TIMEOUT(DS_TIMEOUT)
    ) dut (
        .MB_CLK   (clk),
        .RESET    (rst_n),
        .CPU_AS   (cpu_as),
        .RW       (rw),
        .UDS      (uds),
        .LDS      (lds),
        .FLASH_SEL(flash_sel),
        .FLASH_RD (flash_rd),
        .FLASH_WR (flash_wr),
        .MB_DTACK (mb_dtack),
        .MB_BERR  (mb_berr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wait k rising edges, then settle 1 time unit past the last one.
    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Timestamp model
    // ------------------------------------------------------------------------
    int         m_n;        // rising edges since reset release
    bit         m_busy;     // a flash cycle is in progress
    bit         m_rd;       // it is a read
    int         m_t0;       // edge that accepted the select
    int         m_tds;      // edge that first saw a write strobe, -1 if none
    logic [1:0] m_dsl;      // strobes seen at m_tds
    bit         m_prev_as;  // /AS high at the previous edge

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n       = 0;
            m_busy    = 1'b0;
            m_prev_as = 1'b0;
            m_tds     = -1;
        end else begin
            m_n++;
            if (!m_busy) begin
                if (!cpu_as && flash_sel && m_prev_as) begin
                    m_busy = 1'b1;
                    m_t0   = m_n;
                    m_rd   = rw;
                    m_tds  = -1;
                end
            end else if (cpu_as) begin
                m_busy = 1'b0;
            end else if (!m_rd && m_tds < 0 && !(uds & lds)
                         && (m_n - m_t0) <= DS_TIMEOUT + 1) begin
                m_tds = m_n;
                m_dsl = {uds, lds};
            end
            m_prev_as = cpu_as;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [1:0] exp_rd;
            logic [1:0] exp_wr;
            logic       exp_dt;
            logic       exp_be;
            exp_rd = 2'b11;
            exp_wr = 2'b11;
            exp_dt = 1'b1;
            exp_be = 1'b1;
            if (rst_n && m_busy) begin
                if (m_rd) begin
                    if (!cpu_as) exp_rd = {uds, lds};
                    if (m_n >= m_t0 + READ_WAIT + 1) exp_dt = 1'b0;
                end else if (m_tds >= 0) begin
                    if (m_n >= m_tds + WR_SETUP + 1 && m_n <= m_tds + WR_SETUP + WE_WIDTH)
                        exp_wr = m_dsl;
                    if (m_n >= m_tds + WR_SETUP + WE_WIDTH + 2) exp_dt = 1'b0;
                end else if (m_n >= m_t0 + DS_TIMEOUT + 1) begin
                    exp_be = 1'b0;
                end
            end
            check("cyc_flash_rd", flash_rd, exp_rd);
            check("cyc_flash_wr", flash_wr, exp_wr);
            check("cyc_dtack", {1'b0, mb_dtack}, {1'b0, exp_dt});
            check("cyc_berr", {1'b0, mb_berr}, {1'b0, exp_be});
        end
    end

    // Bound the run in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Directed sequences; "edge k" counts from the edge that samples the select
    // ------------------------------------------------------------------------
    initial begin
        rst_n     = 1'b1;
        cpu_as    = 1'b1;
        rw        = 1'b1;
        uds       = 1'b1;
        lds       = 1'b1;
        flash_sel = 1'b0;
        #1 rst_n  = 1'b0;
        cmp_en    = 1'b1;
        #1;
        check("rst_flash_rd", flash_rd, 2'b11);
        check("rst_flash_wr", flash_wr, 2'b11);
        check("rst_dtack", {1'b0, mb_dtack}, 2'b01);
        check("rst_berr", {1'b0, mb_berr}, 2'b01);
        step(2);
        rst_n = 1'b1;
        step(2);

        // 1: read, then a back-to-back read after one edge of /AS high
        cpu_as = 1'b0; flash_sel = 1'b1; rw = 1'b1; uds = 1'b0; lds = 1'b0;
        step(1);
        check("t1_rd_edge0", flash_rd, 2'b00);
        check("t1_dtack_edge0", {1'b0, mb_dtack}, 2'b01);
        step(1);
        check("t1_dtack_edge1", {1'b0, mb_dtack}, 2'b01);
        step(1);
        check("t1_dtack_edge2", {1'b0, mb_dtack}, 2'b00);
        step(2);
        cpu_as = 1'b1;
        #1 check("t1_rd_as_high", flash_rd, 2'b11);
        step(1);
        check("t1_dtack_edge5", {1'b0, mb_dtack}, 2'b01);
        cpu_as = 1'b0;
        step(3);
        check("t1_b2b_dtack", {1'b0, mb_dtack}, 2'b00);
        cpu_as = 1'b1; flash_sel = 1'b0; uds = 1'b1; lds = 1'b1;
        step(2);

        // 2: write, LDS only; select and UDS wiggle mid-cycle are ignored
        cpu_as = 1'b0; flash_sel = 1'b1; rw = 1'b0;
        step(1);
        check("t2_wr_edge0", flash_wr, 2'b11);
        flash_sel = 1'b0;
        step(2);
        lds = 1'b0;
        step(1);
        check("t2_wr_edge3", flash_wr, 2'b11);
        step(1);
        check("t2_wr_edge4", flash_wr, 2'b11);
        step(1);
        check("t2_wr_edge5", flash_wr, 2'b10);
        uds = 1'b0;
        step(1);
        check("t2_wr_edge6", flash_wr, 2'b10);
        step(1);
        check("t2_wr_edge7", flash_wr, 2'b11);
        check("t2_dtack_edge7", {1'b0, mb_dtack}, 2'b01);
        step(1);
        check("t2_dtack_edge8", {1'b0, mb_dtack}, 2'b00);
        check("t2_rd_in_write", flash_rd, 2'b11);
        cpu_as = 1'b1; uds = 1'b1; lds = 1'b1;
        step(1);
        check("t2_dtack_release", {1'b0, mb_dtack}, 2'b01);
        step(1);

        // 3: write with no data strobe -> bus error
        cpu_as = 1'b0; flash_sel = 1'b1; rw = 1'b0;
        step(13);
        check("t3_berr_edge12", {1'b0, mb_berr}, 2'b01);
        step(1);
        check("t3_berr_edge13", {1'b0, mb_berr}, 2'b00);
        check("t3_dtack_edge13", {1'b0, mb_dtack}, 2'b01);
        check("t3_wr_edge13", flash_wr, 2'b11);
        cpu_as = 1'b1; flash_sel = 1'b0;
        step(1);
        check("t3_berr_release", {1'b0, mb_berr}, 2'b01);
        step(1);

        // 4: abort during the /WE pulse
        cpu_as = 1'b0; flash_sel = 1'b1; rw = 1'b0; uds = 1'b0; lds = 1'b0;
        step(4);
        check("t4_wr_pulse", flash_wr, 2'b00);
        cpu_as = 1'b1; flash_sel = 1'b0;
        step(1);
        check("t4_wr_abort", flash_wr, 2'b11);
        check("t4_dtack_abort", {1'b0, mb_dtack}, 2'b01);
        uds = 1'b1; lds = 1'b1;
        step(3);
        check("t4_dtack_later", {1'b0, mb_dtack}, 2'b01);

        // 5: asynchronous reset during the /WE pulse, then a normal read
        cpu_as = 1'b0; flash_sel = 1'b1; rw = 1'b0; uds = 1'b0; lds = 1'b0;
        step(4);
        check("t5_wr_pulse", flash_wr, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        check("t5_wr_async", flash_wr, 2'b11);
        check("t5_dtack_async", {1'b0, mb_dtack}, 2'b01);
        cpu_as = 1'b1; flash_sel = 1'b0; uds = 1'b1; lds = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(2);
        cpu_as = 1'b0; flash_sel = 1'b1; rw = 1'b1; uds = 1'b0; lds = 1'b1;
        step(3);
        check("t5_read_dtack", {1'b0, mb_dtack}, 2'b00);
        check("t5_read_rd", flash_rd, 2'b01);
        cpu_as = 1'b1; flash_sel = 1'b0; uds = 1'b1;
        step(2);

        // 6: unselected read and write belong to the motherboard
        cpu_as = 1'b0; rw = 1'b1; uds = 1'b0; lds = 1'b0;
        step(6);
        check("t6_rd_unsel", flash_rd, 2'b11);
        check("t6_dtack_unsel_rd", {1'b0, mb_dtack}, 2'b01);
        cpu_as = 1'b1;
        step(1);
        cpu_as = 1'b0; rw = 1'b0; uds = 1'b1;
        step(15);
        check("t6_wr_unsel", flash_wr, 2'b11);
        check("t6_berr_unsel", {1'b0, mb_berr}, 2'b01);
        check("t6_dtack_unsel_wr", {1'b0, mb_dtack}, 2'b01);
        cpu_as = 1'b1; lds = 1'b1;
        step(2);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
